// File: rtl/param_deser_pkg.sv
// Shared types and helpers for the parametrised serial-to-parallel converter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package param_deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // Zero-extension to 64 bits leaves the reduction XOR unchanged.
    function automatic logic parity_fail(input logic [63:0] data, input logic pbit,
                                         input logic odd);
        return (^data ^ pbit) != odd;
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry valid/ready output register for assembled words, with sticky overflow.
// Latency: a written word appears on pdata/valid the edge after wr_vld.
// Backpressure: a word arriving while valid=1 and ready=0 is dropped and sets overflow.
module deser_out_reg
    import param_deser_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_vld,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] pdata,
    output logic              valid,
    input  logic              ready,
    output logic              overflow
`ifdef PARAM_DESER_PARITY_EN
    ,
    input  logic              wr_err,
    output logic              parity_err
`endif
);

    logic can_load;
    assign can_load = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pdata    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
`ifdef PARAM_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (wr_vld) begin
            if (can_load) begin
                // Covers the same-cycle accept-and-refill case: valid stays high.
                pdata <= wr_dat;
                valid <= 1'b1;
`ifdef PARAM_DESER_PARITY_EN
                parity_err <= wr_err;
`endif
            end else begin
                overflow <= 1'b1;
            end
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/param_deserializer.sv
// Serial-to-parallel converter: DATA_W-bit words, either bit order; optional trailing parity (PARAM_DESER_PARITY_EN).
// Latency: valid rises one edge after the last bit (parity bit when enabled) is sampled.
// Backpressure: single output register; words completing while it is full are dropped (overflow).
module param_deserializer
    import param_deser_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sdata,
    input  logic                           start,
    output logic [DATA_W-1:0]              pdata,
    output logic                           valid,
    input  logic                           ready,
    output logic                           aborted,
    output logic                           overflow,
    output logic [bit_cnt_w(DATA_W)-1:0]   bit_cnt
`ifdef PARAM_DESER_PARITY_EN
    ,
    output logic                           parity_err
`endif
);

    localparam int CW = bit_cnt_w(DATA_W);

    if (DATA_W < 2 || DATA_W > 64) begin : g_bad_width
        $error("param_deserializer: DATA_W must be in 2..64");
    end

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sreg, sreg_nxt;
    logic              last_bit;
    logic              shift_en, word_cmp, par_smp, abort_set, deliver;
    logic              done_q;

    assign last_bit = (bit_cnt == CW'(DATA_W - 1));
    assign sreg_nxt = MSB_FIRST ? {sreg[DATA_W-2:0], sdata} : {sdata, sreg[DATA_W-1:1]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        word_cmp  = 1'b0;
        par_smp   = 1'b0;
        abort_set = 1'b0;
        case (state)
            IDLE, SHIFT: begin
                if (start) begin
                    shift_en  = 1'b1;
                    state_nxt = SHIFT;
                    if (last_bit) begin
                        word_cmp = 1'b1;
`ifdef PARAM_DESER_PARITY_EN
                        state_nxt = PARITY;
`endif
                    end
                end else begin
                    state_nxt = IDLE;
                    abort_set = (bit_cnt != '0);
                end
            end
            PARITY: begin
                state_nxt = IDLE;
                if (start) par_smp   = 1'b1;
                else       abort_set = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PARAM_DESER_PARITY_EN
    logic err_q;
    assign deliver = par_smp;

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= par_smp && parity_fail(64'(sreg), sdata, ODD_PARITY);
    end
`else
    assign deliver = word_cmp;

    // Parity sense only matters when the parity check is compiled in.
    if (ODD_PARITY) begin : g_odd_parity_unused
    end
`endif

    // done_q marks that sreg holds a complete word for the output register this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
            done_q  <= 1'b0;
            aborted <= 1'b0;
        end else begin
            done_q  <= deliver;
            aborted <= abort_set;
            if (shift_en) begin
                sreg    <= sreg_nxt;
                bit_cnt <= word_cmp ? '0 : bit_cnt + CW'(1);
            end else if (abort_set) begin
                bit_cnt <= '0;
            end
        end
    end

    deser_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .wr_vld     (done_q),
        .wr_dat     (sreg),
        .pdata      (pdata),
        .valid      (valid),
        .ready      (ready),
        .overflow   (overflow)
`ifdef PARAM_DESER_PARITY_EN
        ,
        .wr_err     (err_q),
        .parity_err (parity_err)
`endif
    );

    // Unused in the non-parity build: the enum still carries PARITY.
    logic unused_par;
    assign unused_par = par_smp;

endmodule

// File: tb/tb_param_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances fed the same serial stream.
module tb_param_deserializer;

    logic        clk = 1'b0;
    logic        reset, sdata, start, ready;
    logic [15:0] pdata_m, pdata_l;
    logic        valid_m, valid_l, aborted_m, aborted_l, overflow_m, overflow_l;
    logic [4:0]  bit_cnt_m, bit_cnt_l;
`ifdef PARAM_DESER_PARITY_EN
    logic        perr_m, perr_l;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [15:0] q_msb[$];
    logic [15:0] q_lsb[$];
    bit          chk_gap = 1'b0;
    bit          have_prev = 1'b0;
    int          prev_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_deserializer #(.DATA_W(16), .MSB_FIRST(1'b1), .ODD_PARITY(1'b0)) u_msb (
        .clk(clk), .reset(reset), .sdata(sdata), .start(start),
        .pdata(pdata_m), .valid(valid_m), .ready(ready),
        .aborted(aborted_m), .overflow(overflow_m), .bit_cnt(bit_cnt_m)
`ifdef PARAM_DESER_PARITY_EN
        , .parity_err(perr_m)
`endif
    );

    param_deserializer #(.DATA_W(16), .MSB_FIRST(1'b0), .ODD_PARITY(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .sdata(sdata), .start(start),
        .pdata(pdata_l), .valid(valid_l), .ready(ready),
        .aborted(aborted_l), .overflow(overflow_l), .bit_cnt(bit_cnt_l)
`ifdef PARAM_DESER_PARITY_EN
        , .parity_err(perr_l)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every accepted word (valid & ready at the negedge) is popped and compared.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid_m && ready) begin
                if (q_msb.size() == 0) check("msb_unexpected_word", 64'(pdata_m), 64'hDEAD_0000);
                else                   check("msb_word", 64'(pdata_m), 64'(q_msb.pop_front()));
                if (chk_gap) begin
                    if (have_prev) check("b2b_interval", 64'(cyc - prev_cyc), 64'd16);
                    prev_cyc  = cyc;
                    have_prev = 1'b1;
                end
            end
            if (valid_l && ready) begin
                if (q_lsb.size() == 0) check("lsb_unexpected_word", 64'(pdata_l), 64'hDEAD_0000);
                else                   check("lsb_word", 64'(pdata_l), 64'(q_lsb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bits go out left to right as written: w[15] first.
    task automatic send_bits(input logic [15:0] w, input int nbits);
        for (int i = 15; i > 15 - nbits; i--) begin
            sdata = w[i];
            start = 1'b1;
            tick();
        end
    endtask

    task automatic send_word(input logic [15:0] w, input logic [15:0] exp_m,
                             input logic [15:0] exp_l, input bit push);
        if (push) begin
            q_msb.push_back(exp_m);
            q_lsb.push_back(exp_l);
        end
        send_bits(w, 16);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        sdata = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic [15:0] bits;
        logic [15:0] exp_msb;
        logic [15:0] exp_lsb;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'hA5A5, 16'hA5A5, 16'hA5A5};
        tbl[1] = '{16'h3C3C, 16'h3C3C, 16'h3C3C};
        tbl[2] = '{16'h8000, 16'h8000, 16'h0001};
        tbl[3] = '{16'h1234, 16'h1234, 16'h2C48};
        tbl[4] = '{16'h0F00, 16'h0F00, 16'h00F0};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};

        reset = 1'b1; sdata = 1'b1; start = 1'b1; ready = 1'b1;
        tick(); tick();
        check("rst_valid",    64'(valid_m),    64'd0);
        check("rst_pdata",    64'(pdata_m),    64'd0);
        check("rst_aborted",  64'(aborted_m),  64'd0);
        check("rst_overflow", 64'(overflow_m), 64'd0);
        check("rst_bit_cnt",  64'(bit_cnt_m),  64'd0);
        check("rst_lsb_bits", 64'(bit_cnt_l),  64'd0);
        reset = 1'b0;
        idle(2);

        // First-word latency: not valid on the last-bit edge, valid one edge later.
        send_word(16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1);
        check("lat_valid_early", 64'(valid_m), 64'd0);
        start = 1'b0;
        tick();
        check("lat_valid",   64'(valid_m), 64'd1);
        check("lat_pdata",   64'(pdata_m), 64'hA5A5);
        check("lat_lsb",     64'(pdata_l), 64'hA5A5);
        check("clean_abort", 64'(aborted_m), 64'd0);
        idle(3);

        // Back-to-back table stream, start held throughout.
        chk_gap   = 1'b1;
        have_prev = 1'b0;
        for (int i = 0; i < 6; i++) send_word(tbl[i].bits, tbl[i].exp_msb, tbl[i].exp_lsb, 1'b1);
        idle(3);
        chk_gap = 1'b0;
        check("stream_drained", 64'(q_msb.size() + q_lsb.size()), 64'd0);

        // Abort after 7 bits, then a clean frame.
        send_bits(16'hFFFF, 7);
        check("abort_bit_cnt", 64'(bit_cnt_m), 64'd7);
        start = 1'b0;
        tick();
        check("abort_pulse",   64'(aborted_m), 64'd1);
        check("abort_lsb",     64'(aborted_l), 64'd1);
        check("abort_novalid", 64'(valid_m),   64'd0);
        tick();
        check("abort_1cycle",  64'(aborted_m), 64'd0);
        check("abort_cnt_clr", 64'(bit_cnt_m), 64'd0);
        send_word(16'h1234, 16'h1234, 16'h2C48, 1'b1);
        idle(3);

        // Overflow with ready low: second word is dropped.
        ready = 1'b0;
        send_word(16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1);
        send_word(16'h3C3C, 16'h3C3C, 16'h3C3C, 1'b0);
        idle(3);
        check("ovf_valid", 64'(valid_m),    64'd1);
        check("ovf_pdata", 64'(pdata_m),    64'hA5A5);
        check("ovf_flag",  64'(overflow_m), 64'd1);
        check("ovf_lsb",   64'(overflow_l), 64'd1);
        ready = 1'b1;
        tick();
        check("ovf_drain_valid", 64'(valid_m),    64'd0);
        idle(2);
        check("ovf_sticky",      64'(overflow_m), 64'd1);

        // Reset at bit 9 with start still high.
        send_bits(16'hFFFF, 9);
        reset = 1'b1;
        tick();
        check("mid_rst_cnt",   64'(bit_cnt_m),  64'd0);
        check("mid_rst_ovf",   64'(overflow_m), 64'd0);
        check("mid_rst_abort", 64'(aborted_m),  64'd0);
        check("mid_rst_pdata", 64'(pdata_m),    64'd0);
        reset = 1'b0;
        idle(1);
        check("mid_rst_noabort", 64'(aborted_m), 64'd0);
        send_word(16'hBEEF, 16'hBEEF, 16'hF77D, 1'b1);
        idle(4);

        check("final_drained", 64'(q_msb.size() + q_lsb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/param_deserializer.md
Name: param_deserializer

Overview:
Parametrised serial-to-parallel converter and successor to the fixed 16-bit deserializer in the SerDes receive path. Samples one bit per clk while start is high, assembles DATA_W-bit words in either bit order, and presents them on a valid/ready output port. Flags aborted frames and overflow, and optionally checks a trailing parity bit. Sits between the receive serial line and the PCIe link-layer word buffer.

Parameters:
DATA_W, 16, word width in bits (2..64).
MSB_FIRST, 1, 1 = first received bit lands in pdata[DATA_W-1]; 0 = first bit lands in pdata[0].
ODD_PARITY, 0, parity sense when the parity feature is compiled in (0 = even, 1 = odd).

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
sdata  in  1  serial data, sampled on every clk edge where start=1.
start  in  1  frame enable; bits are accepted only while high.
pdata  out  DATA_W  assembled word; stable while valid=1.
valid  out  1  pdata holds an unconsumed word.
ready  in  1  consumer accepts pdata when valid and ready are both 1.
aborted  out  1  one-cycle pulse: start fell with a partial word pending.
overflow  out  1  sticky: a completed word was dropped; cleared only by reset.
bit_cnt  out  $clog2(DATA_W+1)  bits collected in the current word (debug).

Behaviour:
- Reset (synchronous, active-high): pdata=0, valid=0, aborted=0, overflow=0, bit_cnt=0, shift register=0, FSM=IDLE. Reset wins over all other inputs in the same cycle, including mid-word; the partial word is discarded with no aborted pulse.
- FSM states and transitions:
  - IDLE -> SHIFT on start=1. The bit present in that same cycle is sampled as bit 0; there is no dead cycle.
  - SHIFT: each start=1 cycle shifts sdata in and increments bit_cnt.
  - On the cycle the DATA_W-th bit is sampled, the word completes and bit_cnt returns to 0. The FSM stays in SHIFT if start=1, allowing back-to-back words with no gap; otherwise it goes to IDLE.
  - start=0 in SHIFT with bit_cnt>0: partial word discarded, aborted pulses for 1 cycle, go to IDLE.
  - start=0 in SHIFT with bit_cnt=0: go to IDLE silently.
- Bit order:
  - MSB_FIRST=1: shift left, inserting at bit 0, so the first bit ends in the MSB.
  - MSB_FIRST=0: shift right, inserting at DATA_W-1, so the first bit ends in bit 0.
- Latency: valid rises on the clk edge after the last bit is sampled. pdata is loaded from the shift register on that same edge.
- Handshake:
  - valid stays high until a cycle with ready=1.
  - Once valid is high, pdata must not change until the word is accepted.
  - A word completing in the same cycle the current word is accepted loads directly into pdata, and valid stays high.
- Overflow: if a word completes while valid=1 and ready=0, the new word is dropped, pdata keeps the old word, and overflow is set (sticky).
- Only one output register; no internal FIFO.

Optional Feature:
Macro PARAM_DESER_PARITY_EN.
- Defined:
  - Each word is followed by one parity bit, sampled while start=1 in a PARITY state entered after bit DATA_W.
  - Parity is checked against ODD_PARITY over the data bits.
  - Adds output parity_err (1 bit), which is valid alongside valid and holds until the word is accepted.
  - The word is always delivered, even when parity fails.
  - start=0 in PARITY counts as an abort: aborted pulses and the word is dropped.
  - valid rises the edge after the parity bit.
- Undefined: no PARITY state, no parity_err port, no ODD_PARITY use.

Decomposition:
- Package param_deser_pkg holds:
  - the FSM state enum (IDLE, SHIFT, PARITY);
  - the function bit_cnt_w(DATA_W) returning $clog2(DATA_W+1);
  - a parity helper function.
- One sub-module, deser_out_reg: the single-entry valid/ready output register with overflow detection.
- The shift/FSM logic stays in the top module.

Test Plan:
- DATA_W=16, MSB_FIRST=1, ready=1; send bits 1010010110100101 -> pdata=16'hA5A5 with valid high 1 cycle after the 16th bit; then send 0011110000111100 back-to-back -> pdata=16'h3C3C with no gap cycle.
- MSB_FIRST=0; send the same 1010010110100101 sequence -> pdata=16'hA5A5 (palindromic check), then send 0011110000111100 -> pdata=16'h3C3C; then send 1,followed by fifteen 0 bits -> pdata=16'h0001.
- Drop start after 7 bits -> aborted pulses exactly 1 cycle, valid stays 0, and the next full 16-bit frame 16'h1234 is received correctly.
- ready=0; send 0xA5A5 then 0x3C3C -> pdata stays 16'hA5A5 and overflow=1; raise ready -> valid falls; overflow stays 1 until reset.
- Assert reset at bit 9 of a frame -> all outputs 0 next cycle, no aborted pulse; frame 16'hBEEF received afterwards is correct.
- With PARAM_DESER_PARITY_EN, ODD_PARITY=0, DATA_W=8: send 8'hA5 with parity bit 0 -> parity_err=0; send 8'hA5 with parity bit 1 -> parity_err=1 and pdata=8'hA5.
